// File: rtl/mon_dff_if.sv
// mon_dff_if: valid/ready word stream leaving the DFF capture stage.
//   m_valid  head word present
//   m_ready  consumer accepts the head word
//   m_data   packed word, bit 0 = earliest sampled bit
//   m_nbits  number of valid bits in m_data
//   m_id     stream tag
// master = capture stage, slave = forwarding consumer.
interface mon_dff_if #(
  parameter int WIDTH = 32
);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [5:0]       m_nbits;
  logic [7:0]       m_id;

  modport master (output m_valid, m_data, m_nbits, m_id, input m_ready);
  modport slave  (input m_valid, m_data, m_nbits, m_id, output m_ready);
endinterface

// File: rtl/mon_dff.sv
// mon_dff: capture stage downstream of the DFF under test.
// Samples `dout` on qualified clocks, packs bits LSB-first into WIDTH-bit
// words and queues completed or flushed words in a first-word-fall-through
// FIFO that drives a valid/ready stream.
//   clk, rst   clock (posedge) and async active-low reset
//   en         sample qualifier for dout
//   dout       DUT output bit
//   flush      push the partial word
//   m          stream out (master modport)
//   level      FIFO occupancy 0..DEPTH
//   overflow   sticky, a word was dropped on a full FIFO
module mon_dff #(
  parameter logic [7:0] id    = 8'd0,
  parameter int         WIDTH = 32,
  parameter int         DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   dout,
  input  logic                   flush,
  mon_dff_if.master              m,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [5:0]       nbits;
    logic [WIDTH-1:0] data;
  } entry_t;

  // ---------------- packer ----------------
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_new;
  logic             last_bit;
  logic             push;
  entry_t           push_ent;

  // sreg_new already holds this edge's bit, so a push on the completing
  // or flushing edge carries it without an extra cycle.
  always_comb begin
    sreg_new = sreg;
    if (en) sreg_new[bit_cnt] = dout;
    last_bit = en && (bit_cnt == CW'(WIDTH - 1));
    // en=0 flush of an empty word produces nothing
    push = last_bit || (flush && (en || (bit_cnt != '0)));
    push_ent.data  = sreg_new;
    push_ent.nbits = last_bit ? 6'(WIDTH) : (6'(bit_cnt) + (en ? 6'd1 : 6'd0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      sreg    <= '0;
    end else if (push) begin
      bit_cnt <= '0;
      sreg    <= '0;
    end else if (en) begin
      bit_cnt <= bit_cnt + 1'b1;
      sreg    <= sreg_new;
    end
  end

  // ---------------- FIFO ----------------
  // Pointers carry one extra wrap bit so full and empty differ.
  logic [AW:0] wr_ptr, rd_ptr;
  entry_t      mem [DEPTH];
  logic        empty, full, pop, wr_en;

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop   = !empty && m.m_ready;
    // a coincident pop frees the slot, so a push on a full FIFO still lands
    wr_en = push && (!full || pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the read side is gated by empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_ent;
  end

  always_comb begin
    level     = wr_ptr - rd_ptr;
    m.m_valid = !empty;
    m.m_data  = empty ? '0 : mem[rd_ptr[AW-1:0]].data;
    m.m_nbits = empty ? '0 : mem[rd_ptr[AW-1:0]].nbits;
    m.m_id    = id;
  end
endmodule
